aurora_nfc_tx_throttle: RTL

- Remote end of the Aurora native-flow-control (NFC) loop. Sits on the TX stream between the SG-bus-to-Aurora width scaler and the Aurora core TX port.
- Decodes NFC messages received from the link partner and pauses or resumes the outgoing AXI-Stream at beat boundaries without dropping or duplicating beats.
- Adds an XOFF watchdog so a lost XON cannot stall the TX path forever.

---
 rtl/aurora_nfc_tx_throttle_pkg.sv | 51 +++++
 rtl/aurora_nfc_tx_throttle_axis_reg_slice.sv | 43 ++++
 rtl/aurora_nfc_tx_throttle.sv | 133 +++++++++++++
 3 files changed

// File: rtl/aurora_nfc_tx_throttle_pkg.sv
// Shared types for the Aurora NFC TX throttle.
// Stream structs, NFC message constants and the throttle state enum.
package aurora_nfc_tx_throttle_pkg;

  localparam int AXIS_DATA_WIDTH = 64;

  localparam logic [15:0] NFC_XON = 16'h0000;
  localparam logic [15:0] NFC_XOFF = 16'h0010;
  localparam int NFC_XOFF_BIT = 4;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
  } axis_payload_t;

  typedef struct packed {
    logic          tvalid;
    axis_payload_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_resp_t;

  typedef enum logic [1:0] {
    RUN,
    PAUSE,
    XOFF
  } nfc_state_e;

  typedef enum logic [1:0] {
    MSG_IGN,
    MSG_XON,
    MSG_XOFF,
    MSG_PAUSE
  } nfc_msg_e;

  function automatic nfc_msg_e decode_msg(
    input logic [15:0] msg
  );
    nfc_msg_e kind;
    kind = MSG_IGN;
    unique case (1'b1)
      (msg == NFC_XON):    kind = MSG_XON;
      msg[NFC_XOFF_BIT]:   kind = MSG_XOFF;
      (msg[15:8] != 8'd0): kind = MSG_PAUSE;
      default:             kind = MSG_IGN;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/aurora_nfc_tx_throttle_axis_reg_slice.sv
// One-deep AXI-Stream output register with an acceptance gate.
// The gate only blocks new beats; a presented beat always completes.
module axis_reg_slice #(
  parameter type req_t  = logic,
  parameter type resp_t = logic,
  parameter int  DataWidth = 64
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  gate,
  input  req_t  s_req,
  output resp_t s_resp,
  output req_t  m_req,
  input  resp_t m_resp
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic                 ready;

  assign ready = gate && (!valid_q || m_resp.tready);

  always_comb begin
    s_resp = '0;
    s_resp.tready = ready;
    m_req = '0;
    m_req.tvalid = valid_q;
    m_req.t.data = data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready) begin
      valid_q <= s_req.tvalid;
      if (s_req.tvalid) data_q <= s_req.t.data;
    end else if (m_resp.tready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aurora_nfc_tx_throttle.sv
// Aurora NFC TX throttle: pauses the TX stream on XOFF/PAUSE messages.
// Optional NFC_THROTTLE_STATS_EN adds pause_cycles and nfc_msg_count.
module aurora_nfc_tx_throttle
  import aurora_nfc_tx_throttle_pkg::*;
#(
  parameter type axis_req_t  =
    aurora_nfc_tx_throttle_pkg::axis_req_t,
  parameter type axis_resp_t =
    aurora_nfc_tx_throttle_pkg::axis_resp_t,
  parameter int DataWidth = 64,
  parameter int TimeoutWidth = 16,
  parameter logic [TimeoutWidth-1:0] XoffTimeout = '1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  axis_req_t   s_axis_req,
  output axis_resp_t  s_axis_resp,
  output axis_req_t   m_axis_req,
  input  axis_resp_t  m_axis_resp,
  input  logic        nfc_rx_tvalid,
  input  logic [15:0] nfc_rx_tdata,
  output logic        tx_paused,
  output logic        xoff_timeout
`ifdef NFC_THROTTLE_STATS_EN
  ,
  output logic [31:0] pause_cycles,
  output logic [15:0] nfc_msg_count
`endif
);

  nfc_state_e state;
  nfc_msg_e   msg;
  logic [7:0] pcnt;
  logic [TimeoutWidth-1:0] wdog;
  logic [TimeoutWidth-1:0] wdog_inc;
  logic       timed_out;
  logic       gate;

  assign msg = nfc_rx_tvalid ? decode_msg(nfc_rx_tdata)
                             : MSG_IGN;
  assign wdog_inc = (&wdog) ? wdog : wdog + 1'b1;
  assign timed_out = (XoffTimeout != '0) &&
                     (wdog_inc >= XoffTimeout);

  // gate mirrors (state == RUN) but stays shut while in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      pcnt         <= '0;
      wdog         <= '0;
      gate         <= 1'b0;
      tx_paused    <= 1'b0;
      xoff_timeout <= 1'b0;
    end else begin
      xoff_timeout <= 1'b0;
      unique case (msg)
        MSG_XON: begin
          state     <= RUN;
          gate      <= 1'b1;
          tx_paused <= 1'b0;
        end
        MSG_XOFF: begin
          state     <= XOFF;
          wdog      <= '0;
          gate      <= 1'b0;
          tx_paused <= 1'b1;
        end
        MSG_PAUSE: begin
          state     <= PAUSE;
          pcnt      <= nfc_rx_tdata[15:8];
          gate      <= 1'b0;
          tx_paused <= 1'b1;
        end
        default: begin
          unique case (state)
            PAUSE: begin
              pcnt <= pcnt - 8'd1;
              if (pcnt == 8'd1) begin
                state     <= RUN;
                gate      <= 1'b1;
                tx_paused <= 1'b0;
              end
            end
            XOFF: begin
              wdog <= wdog_inc;
              if (timed_out) begin
                state        <= RUN;
                gate         <= 1'b1;
                tx_paused    <= 1'b0;
                xoff_timeout <= 1'b1;
              end
            end
            default: begin
              state     <= RUN;
              gate      <= 1'b1;
              tx_paused <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

`ifdef NFC_THROTTLE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_cycles  <= '0;
      nfc_msg_count <= '0;
    end else begin
      if (tx_paused && s_axis_req.tvalid &&
          (pause_cycles != '1))
        pause_cycles <= pause_cycles + 32'd1;
      if (msg != MSG_IGN)
        nfc_msg_count <= nfc_msg_count + 16'd1;
    end
  end
`endif

  axis_reg_slice #(
    .req_t     (axis_req_t),
    .resp_t    (axis_resp_t),
    .DataWidth (DataWidth)
  ) u_slice (
    .clk     (clk),
    .reset_n (reset_n),
    .gate    (gate),
    .s_req   (s_axis_req),
    .s_resp  (s_axis_resp),
    .m_req   (m_axis_req),
    .m_resp  (m_axis_resp)
  );

endmodule
